dmem_arbiter: RTL and testbench

Shares the single-port data memory between the pipeline MEM stage (requester 0, "cpu") and an external program/data loader (requester 1, "ld"), such as a UART or debug loader. The CPU keeps combinational, same-cycle access whenever it owns the memory. The loader gets one-word transactions through a req/ack handshake. A starvation counter guarantees the loader a slot, and the block drives a stall to the pipeline while the loader owns the memory. It sits between the MEM-stage signals and the data memory, in the slow_clk domain.

---
 rtl/dmem_arbiter_if.sv | 53 +++++
 rtl/dmem_arbiter.sv | 91 +++++++++
 tb/tb_dmem_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between MEM stage, loader, data memory and the arbiter.
// slave = arbiter view; master = requesters and memory view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_byte;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic              mem_byte;
  logic [DATA_W-1:0] mem_rdata;
  logic              owner_ld;

  modport slave (
    input  cpu_req, cpu_we, cpu_byte,
    input  cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ld_req, ld_we,
    input  ld_addr, ld_wdata,
    output ld_rdata, ld_ack,
    output mem_addr, mem_wdata,
    output mem_read, mem_write, mem_byte,
    input  mem_rdata,
    output owner_ld
  );

  modport master (
    output cpu_req, cpu_we, cpu_byte,
    output cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ld_req, ld_we,
    output ld_addr, ld_wdata,
    input  ld_rdata, ld_ack,
    input  mem_addr, mem_wdata,
    input  mem_read, mem_write, mem_byte,
    output mem_rdata,
    input  owner_ld
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data memory arbiter: CPU (MEM stage) vs loader, one-word loader slots.
// Ports: clk, reset (async, active-low), bus (dmem_arbiter_if.slave).
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_CPU = 2'd0,
    S_LD  = 2'd1,
    S_ACK = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

  state_t            state;
  logic [7:0]        wait_cnt;
  logic [DATA_W-1:0] ld_rdata_q;
  logic              ld_ack_q;
  logic              grant;

  // Loader wins when the CPU is idle or it has waited long enough.
  assign grant = bus.ld_req &
                 (~bus.cpu_req | (wait_cnt == LIMIT_M1));

  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_read  = bus.cpu_req & ~bus.cpu_we;
    bus.mem_write = bus.cpu_req &  bus.cpu_we;
    bus.mem_byte  = bus.cpu_byte;
    bus.cpu_stall = 1'b0;
    bus.owner_ld  = 1'b0;
    if (state == S_LD) begin
      bus.mem_addr  = bus.ld_addr;
      bus.mem_wdata = bus.ld_wdata;
      bus.mem_read  = ~bus.ld_we;
      bus.mem_write =  bus.ld_we;
      bus.mem_byte  = 1'b0;
      bus.cpu_stall = bus.cpu_req;
      bus.owner_ld  = 1'b1;
    end
  end

  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.ld_rdata  = ld_rdata_q;
  assign bus.ld_ack    = ld_ack_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_CPU;
      wait_cnt   <= 8'd0;
      ld_rdata_q <= '0;
      ld_ack_q   <= 1'b0;
    end else begin
      unique case (state)
        S_CPU: begin
          if (grant) begin
            state    <= S_LD;
            wait_cnt <= 8'd0;
          end else if (bus.ld_req) begin
            wait_cnt <= wait_cnt + 8'd1;
          end else begin
            wait_cnt <= 8'd0;
          end
        end
        S_LD: begin
          if (!bus.ld_we)
            ld_rdata_q <= bus.mem_rdata;
          ld_ack_q <= 1'b1;
          state    <= S_ACK;
        end
        S_ACK: begin
          // Always hand one slot back to the CPU.
          ld_ack_q <= 1'b0;
          state    <= S_CPU;
        end
        default: begin
          ld_ack_q <= 1'b0;
          state    <= S_CPU;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256-word memory model.
// Ports exercised through dmem_arbiter_if; STARVE_LIMIT = 8.
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   wr_cnt;
  logic [31:0] mem [256];

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_addr[7:0]] = bus.mem_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic own_exp [6];
  logic ack_exp [6];
  int   wr_base;

  initial begin
    checks   = 0;
    failures = 0;
    wr_cnt   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'h0BAD_F00D;
    mem[8'h30] = 32'h1234_5678;
    own_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ack_exp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    reset         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_byte  = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.ld_req    = 1'b0;
    bus.ld_we     = 1'b0;
    bus.ld_addr   = 32'h0;
    bus.ld_wdata  = 32'h0;

    // 1: reset release, CPU same-cycle read
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk1("rst_owner", bus.owner_ld, 1'b0);
    chk1("rst_stall", bus.cpu_stall, 1'b0);
    chk1("rst_ack", bus.ld_ack, 1'b0);
    chk32("rst_ldrdata", bus.ld_rdata, 32'h0);
    chk1("rst_mrd", bus.mem_read, 1'b0);
    chk1("rst_mwr", bus.mem_write, 1'b0);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h10;
    bus.cpu_byte = 1'b1;
    #1;
    chk32("t1_maddr", bus.mem_addr, 32'h10);
    chk1("t1_mrd", bus.mem_read, 1'b1);
    chk1("t1_mbyte", bus.mem_byte, 1'b1);
    chk1("t1_stall", bus.cpu_stall, 1'b0);
    chk32("t1_rdata", bus.cpu_rdata, 32'h0BAD_F00D);
    tick();
    bus.cpu_req  = 1'b0;
    bus.cpu_byte = 1'b0;

    // 2: uncontended loader write
    wr_base      = wr_cnt;
    bus.ld_req   = 1'b1;
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 32'h20;
    bus.ld_wdata = 32'hDEAD_BEEF;
    #1;
    chk1("t2_mwr_pre", bus.mem_write, 1'b0);
    tick();
    chk1("t2_owner", bus.owner_ld, 1'b1);
    chk1("t2_mwr", bus.mem_write, 1'b1);
    chk32("t2_maddr", bus.mem_addr, 32'h20);
    chk1("t2_ack_e1", bus.ld_ack, 1'b0);
    tick();
    chk1("t2_ack_e2", bus.ld_ack, 1'b1);
    chk1("t2_mwr_ack", bus.mem_write, 1'b0);
    chk1("t2_owner_ack", bus.owner_ld, 1'b0);
    bus.ld_req = 1'b0;
    bus.ld_we  = 1'b0;
    tick();
    chk1("t2_ack_clr", bus.ld_ack, 1'b0);
    chk32("t2_wrcnt", 32'(wr_cnt - wr_base), 32'd1);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h20;
    #1;
    chk32("t2_rdback", bus.cpu_rdata, 32'hDEAD_BEEF);

    // 3: starvation grant on 8th contended cycle
    bus.cpu_byte = 1'b1;
    bus.ld_req   = 1'b1;
    bus.ld_addr  = 32'h30;
    #1;
    chk1("t3_own0", bus.owner_ld, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk1("t3_wait_own", bus.owner_ld, 1'b0);
      chk1("t3_wait_stall", bus.cpu_stall, 1'b0);
    end
    tick();
    chk1("t3_grant", bus.owner_ld, 1'b1);
    chk1("t3_stall", bus.cpu_stall, 1'b1);
    chk32("t3_maddr", bus.mem_addr, 32'h30);
    chk1("t3_mbyte", bus.mem_byte, 1'b0);
    chk1("t3_mrd", bus.mem_read, 1'b1);
    tick();
    chk1("t3_ack", bus.ld_ack, 1'b1);
    chk1("t3_stall_ack", bus.cpu_stall, 1'b0);
    chk32("t3_ldrdata", bus.ld_rdata, 32'h1234_5678);
    chk32("t3_cpu_maddr", bus.mem_addr, 32'h20);
    chk32("t3_cpu_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    bus.ld_req   = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_byte = 1'b0;
    tick();

    // 4: CPU store held off during S_LD, done once in S_ACK
    wr_base     = wr_cnt;
    bus.ld_req  = 1'b1;
    bus.ld_we   = 1'b0;
    bus.ld_addr = 32'h20;
    tick();
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h40;
    bus.cpu_wdata = 32'hA5A5_A5A5;
    #1;
    chk1("t4_owner", bus.owner_ld, 1'b1);
    chk1("t4_mwr_ld", bus.mem_write, 1'b0);
    chk1("t4_stall", bus.cpu_stall, 1'b1);
    chk32("t4_maddr_ld", bus.mem_addr, 32'h20);
    tick();
    chk1("t4_mwr_ack", bus.mem_write, 1'b1);
    chk32("t4_maddr_ack", bus.mem_addr, 32'h40);
    chk32("t4_ldrdata", bus.ld_rdata, 32'hDEAD_BEEF);
    bus.ld_req = 1'b0;
    tick();
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    #1;
    chk32("t4_wrcnt", 32'(wr_cnt - wr_base), 32'd1);
    chk32("t4_mem40", mem[8'h40], 32'hA5A5_A5A5);

    // 5: loader holds ld_req continuously
    bus.ld_req  = 1'b1;
    bus.ld_addr = 32'h30;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1("t5_owner", bus.owner_ld, own_exp[i]);
      chk1("t5_ack", bus.ld_ack, ack_exp[i]);
    end
    bus.ld_req = 1'b0;
    tick();
    chk1("t5_idle", bus.owner_ld, 1'b0);

    // 6: async reset in S_LD aborts the transaction
    bus.ld_req  = 1'b1;
    bus.ld_addr = 32'h10;
    tick();
    chk1("t6_owner", bus.owner_ld, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk1("t6_owner_rst", bus.owner_ld, 1'b0);
    chk1("t6_ack_rst", bus.ld_ack, 1'b0);
    chk32("t6_ldrdata_rst", bus.ld_rdata, 32'h0);
    chk1("t6_mrd_rst", bus.mem_read, 1'b0);
    bus.ld_req = 1'b0;
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("t6_no_ack", bus.ld_ack, 1'b0);
      chk1("t6_no_owner", bus.owner_ld, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
